score_ctl: RTL and testbench



---
 rtl/pong_pkg.sv | 21 ++
 rtl/edge_rise.sv | 21 ++
 rtl/score_ctl.sv | 132 +++++++++++++
 tb/tb_score_ctl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared pong types and constants so the score keeper and the overlay agree on
// score width and default match settings.
package pong_pkg;

   typedef enum logic [1:0] {
      PLAY  = 2'd0,
      PAUSE = 2'd1,
      OVER  = 2'd2
   } score_state_t;

   localparam int SCORE_W          = 4;
   localparam int SCORE_MAX        = 15;
   localparam int DEF_WIN_SCORE    = 9;
   localparam int DEF_PAUSE_CYCLES = 65_000_000;

   // Scores stick at the top value instead of wrapping back to zero.
   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
      return (s == SCORE_W'(SCORE_MAX)) ? s : s + 1'b1;
   endfunction

endpackage

// File: rtl/edge_rise.sv
// Single-bit rising-edge detector; the history register resets to RESET_VAL so
// a level already high when reset releases does not look like a fresh edge.
module edge_rise #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise
);

   logic din_q;

   always_ff @(posedge clk) begin
      if (rst) din_q <= RESET_VAL;
      else     din_q <= din;
   end

   assign rise = din & ~din_q;

endmodule

// File: rtl/score_ctl.sv
// Score keeper and serve/pause sequencer for pong.
// Optional build macro SCORE_WIN_BY_TWO_EN: require a two-point lead (or 15) to win.
module score_ctl
   import pong_pkg::*;
#(
   parameter int WIN_SCORE    = DEF_WIN_SCORE,
   parameter int PAUSE_CYCLES = DEF_PAUSE_CYCLES,
   parameter int CNT_W        = 26
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                goal_left,
   input  logic                goal_right,
   input  logic                new_game,
   output logic [SCORE_W-1:0]  player1_score,
   output logic [SCORE_W-1:0]  player2_score,
   output logic                point_scored,
   output logic                pause,
   output logic                serve_dir,
   output logic                game_over,
   output logic                winner
);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PAUSE_CYCLES - 1);

   logic rise_left, rise_right;

   edge_rise #(.RESET_VAL(1'b1)) u_rise_left (
      .clk (clk), .rst (rst), .din (goal_left),  .rise (rise_left)
   );
   edge_rise #(.RESET_VAL(1'b1)) u_rise_right (
      .clk (clk), .rst (rst), .din (goal_right), .rise (rise_right)
   );

   score_state_t       state, state_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic [SCORE_W-1:0] p1_n, p2_n, new_score, other_score;
   logic               ps_n, pause_n, dir_n, over_n, winner_n, win_hit;

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      p1_n     = player1_score;
      p2_n     = player2_score;
      ps_n     = 1'b0;
      pause_n  = pause;
      dir_n    = serve_dir;
      over_n   = game_over;
      winner_n = winner;

      new_score   = sat_inc(rise_right ? player1_score : player2_score);
      other_score = rise_right ? player2_score : player1_score;
`ifdef SCORE_WIN_BY_TWO_EN
      win_hit = (new_score == SCORE_W'(SCORE_MAX)) ||
                ((5'(new_score) >= 5'(WIN_SCORE)) &&
                 (5'(new_score) >= 5'(other_score) + 5'd2));
`else
      win_hit = (new_score == SCORE_W'(WIN_SCORE));
`endif

      if (new_game) begin
         state_n  = PAUSE;
         cnt_n    = CNT_LOAD;
         p1_n     = '0;
         p2_n     = '0;
         pause_n  = 1'b1;
         dir_n    = 1'b0;
         over_n   = 1'b0;
         winner_n = 1'b0;
      end else begin
         case (state)
            PLAY: begin
               // Simultaneous edges are ambiguous, so neither side is credited.
               if (rise_left ^ rise_right) begin
                  ps_n    = 1'b1;
                  dir_n   = rise_right;
                  pause_n = 1'b1;
                  if (rise_right) p1_n = new_score;
                  else            p2_n = new_score;
                  if (win_hit) begin
                     state_n  = OVER;
                     over_n   = 1'b1;
                     winner_n = rise_left;
                  end else begin
                     state_n = PAUSE;
                     cnt_n   = CNT_LOAD;
                  end
               end
            end
            PAUSE: begin
               if (cnt == '0) begin
                  state_n = PLAY;
                  pause_n = 1'b0;
               end else begin
                  cnt_n = cnt - 1'b1;
               end
            end
            OVER:    pause_n = 1'b1;
            default: begin
               state_n = PAUSE;
               cnt_n   = CNT_LOAD;
               pause_n = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= PAUSE;
         cnt           <= CNT_LOAD;
         player1_score <= '0;
         player2_score <= '0;
         point_scored  <= 1'b0;
         pause         <= 1'b1;
         serve_dir     <= 1'b0;
         game_over     <= 1'b0;
         winner        <= 1'b0;
      end else begin
         state         <= state_n;
         cnt           <= cnt_n;
         player1_score <= p1_n;
         player2_score <= p2_n;
         point_scored  <= ps_n;
         pause         <= pause_n;
         serve_dir     <= dir_n;
         game_over     <= over_n;
         winner        <= winner_n;
      end
   end

endmodule

// File: tb/tb_score_ctl.sv
// Bench for score_ctl with short pause and low winning score; outputs are
// compared every cycle against a behavioural match model plus fixed vectors.
module tb_score_ctl;

   localparam int WIN = 3;
   localparam int PC  = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       goal_left = 1'b0, goal_right = 1'b0, new_game = 1'b0;
   logic [3:0] player1_score, player2_score;
   logic       point_scored, pause, serve_dir, game_over, winner;

   score_ctl #(.WIN_SCORE(WIN), .PAUSE_CYCLES(PC), .CNT_W(3)) dut (
      .clk           (clk),
      .rst           (rst),
      .goal_left     (goal_left),
      .goal_right    (goal_right),
      .new_game      (new_game),
      .player1_score (player1_score),
      .player2_score (player2_score),
      .point_scored  (point_scored),
      .pause         (pause),
      .serve_dir     (serve_dir),
      .game_over     (game_over),
      .winner        (winner)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Match model: scores, frozen flag, remaining frozen cycles, last goal levels.
   int m_p1, m_p2, m_ps, m_pause, m_dir, m_over, m_win, m_left, m_pgl, m_pgr;

   typedef struct {
      int gl, gr, ng;
      int p1, p2, ps, pa, dir, ov, wn;
   } vec_t;

   function automatic vec_t mk(int gl, int gr, int ng, int p1, int p2,
                               int ps, int pa, int dir, int ov, int wn);
      vec_t v;
      v = '{gl, gr, ng, p1, p2, ps, pa, dir, ov, wn};
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int match_won(int s, int o);
`ifdef SCORE_WIN_BY_TWO_EN
      return int'((s >= WIN && s - o >= 2) || s == 15);
`else
      return int'(s == WIN);
`endif
   endfunction

   task automatic model_edge(input int gl, input int gr, input int ng, input int r);
      int rl, rr, s, o;
      if (r != 0) begin
         m_p1 = 0; m_p2 = 0; m_ps = 0; m_pause = 1; m_dir = 0;
         m_over = 0; m_win = 0; m_left = PC; m_pgl = 1; m_pgr = 1;
         return;
      end
      rl = int'(gl != 0 && m_pgl == 0);
      rr = int'(gr != 0 && m_pgr == 0);
      m_pgl = gl; m_pgr = gr;
      m_ps = 0;
      if (ng != 0) begin
         m_p1 = 0; m_p2 = 0; m_over = 0; m_win = 0; m_dir = 0;
         m_pause = 1; m_left = PC;
      end else if (m_over != 0) begin
         m_pause = 1;
      end else if (m_pause != 0) begin
         m_left--;
         if (m_left == 0) m_pause = 0;
      end else if (rl + rr == 1) begin
         if (rr != 0) begin
            m_p1 = (m_p1 < 15) ? m_p1 + 1 : 15; s = m_p1; o = m_p2;
         end else begin
            m_p2 = (m_p2 < 15) ? m_p2 + 1 : 15; s = m_p2; o = m_p1;
         end
         m_ps = 1; m_dir = rr; m_pause = 1;
         if (match_won(s, o) != 0) begin
            m_over = 1; m_win = rl;
         end else begin
            m_left = PC;
         end
      end
   endtask

   task automatic step(input logic gl, input logic gr, input logic ng, input logic r);
      @(negedge clk);
      goal_left = gl; goal_right = gr; new_game = ng; rst = r;
      @(posedge clk);
      model_edge(int'(gl), int'(gr), int'(ng), int'(r));
      #1;
      chk("model p1",    int'(player1_score), m_p1);
      chk("model p2",    int'(player2_score), m_p2);
      chk("model point", int'(point_scored),  m_ps);
      chk("model pause", int'(pause),         m_pause);
      chk("model dir",   int'(serve_dir),     m_dir);
      chk("model over",  int'(game_over),     m_over);
      if (m_over != 0) chk("model winner", int'(winner), m_win);
   endtask

   vec_t tbl[30];

   initial begin
      tbl = '{
         mk(0,0,0, 0,0,0,1,0,0,0), mk(0,0,0, 0,0,0,1,0,0,0), mk(0,0,0, 0,0,0,1,0,0,0),
         mk(0,0,0, 0,0,0,0,0,0,0), mk(0,1,0, 1,0,1,1,1,0,0), mk(0,1,0, 1,0,0,1,1,0,0),
         mk(0,1,0, 1,0,0,1,1,0,0), mk(0,1,0, 1,0,0,1,1,0,0), mk(0,1,0, 1,0,0,0,1,0,0),
         mk(0,1,0, 1,0,0,0,1,0,0), mk(1,0,0, 1,1,1,1,0,0,0), mk(0,1,0, 1,1,0,1,0,0,0),
         mk(0,0,0, 1,1,0,1,0,0,0), mk(0,1,0, 1,1,0,1,0,0,0), mk(0,0,0, 1,1,0,0,0,0,0),
         mk(1,1,0, 1,1,0,0,0,0,0), mk(0,0,0, 1,1,0,0,0,0,0), mk(1,0,0, 1,2,1,1,0,0,0),
         mk(0,0,0, 1,2,0,1,0,0,0), mk(0,0,0, 1,2,0,1,0,0,0), mk(0,0,0, 1,2,0,1,0,0,0),
         mk(0,0,0, 1,2,0,0,0,0,0), mk(1,0,0, 1,3,1,1,0,1,1), mk(0,1,0, 1,3,0,1,0,1,1),
         mk(0,0,0, 1,3,0,1,0,1,1), mk(0,0,1, 0,0,0,1,0,0,0), mk(0,0,0, 0,0,0,1,0,0,0),
         mk(0,0,0, 0,0,0,1,0,0,0), mk(0,0,0, 0,0,0,1,0,0,0), mk(0,0,0, 0,0,0,0,0,0,0)
      };

      // goal_left held high through and after reset must not score
      step(1, 0, 0, 1);
      step(1, 0, 0, 1);
      for (int i = 1; i <= 4; i++) begin
         step(1, 0, 0, 0);
         chk("held goal pause", int'(pause), int'(i < 4));
         chk("held goal p2", int'(player2_score), 0);
         chk("held goal point", int'(point_scored), 0);
      end

      step(0, 0, 0, 1);
      for (int i = 0; i < 30; i++) begin
         step(tbl[i].gl != 0, tbl[i].gr != 0, tbl[i].ng != 0, 1'b0);
         chk($sformatf("vec%0d p1", i),    int'(player1_score), tbl[i].p1);
         chk($sformatf("vec%0d p2", i),    int'(player2_score), tbl[i].p2);
         chk($sformatf("vec%0d point", i), int'(point_scored),  tbl[i].ps);
         chk($sformatf("vec%0d pause", i), int'(pause),         tbl[i].pa);
         chk($sformatf("vec%0d dir", i),   int'(serve_dir),     tbl[i].dir);
         chk($sformatf("vec%0d over", i),  int'(game_over),     tbl[i].ov);
         chk($sformatf("vec%0d winner", i), int'(winner),       tbl[i].wn);
      end

      // new_game wins over a goal edge in the same cycle
      step(0, 1, 1, 0);
      chk("ng priority point", int'(point_scored), 0);
      chk("ng priority p1", int'(player1_score), 0);
      chk("ng priority pause", int'(pause), 1);

      // reset in the middle of a pause restarts the full pause
      step(0, 0, 0, 0);
      step(0, 0, 0, 1);
      for (int i = 1; i <= 4; i++) begin
         step(0, 0, 0, 0);
         chk("rst mid pause", int'(pause), int'(i < 4));
      end

`ifdef SCORE_WIN_BY_TWO_EN
      begin
         logic sides[6];
         sides = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
         for (int k = 0; k < 6; k++) begin
            step(!sides[k], sides[k], 0, 0);
            if (k == 4) begin
               chk("by2 3-2 p1", int'(player1_score), 3);
               chk("by2 3-2 over", int'(game_over), 0);
            end
            if (k == 5) begin
               chk("by2 4-2 p1", int'(player1_score), 4);
               chk("by2 4-2 over", int'(game_over), 1);
               chk("by2 4-2 winner", int'(winner), 0);
            end
            for (int j = 0; j < PC; j++) step(0, 0, 0, 0);
         end
      end
`endif

      for (int n = 0; n < 4000; n++) begin
         step(($urandom % 4) == 0, ($urandom % 4) == 0,
              ($urandom % 60) == 0, ($urandom % 200) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
